// File: rtl/ioctl_ram_uploader.sv
// Pauses the CPU and streams a RAM window to the HPS over ioctl, one byte for each ioctl_rd strobe.
// An in-window byte lands on ioctl_din RAM_LAT+1 clocks after its strobe; the HPS paces the transfer, with no backpressure.
module ioctl_ram_uploader #(
  parameter int          ADDR_W       = 12,
  parameter int          LEN_W        = 12,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter int          RAM_LAT      = 1,
  parameter logic [23:0] TIMEOUT      = 24'd12000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic              paused,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_upload_req,
  output logic              pause_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, PAUSE_WAIT, REQ, XFER} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [23:0]       timer;
  logic [1:0]        pend_cnt;
  logic              pend_zero;

  logic in_window;
  logic strobe;
  logic upload_end;

  assign in_window  = ioctl_addr < 25'(len_q);
  assign strobe     = (state == XFER) && ioctl_upload && ioctl_rd;
  assign upload_end = (state == XFER) && !ioctl_upload;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      base_q           <= '0;
      len_q            <= '0;
      timer            <= '0;
      pend_cnt         <= '0;
      pend_zero        <= 1'b0;
      ioctl_din        <= 8'h00;
      ioctl_upload_req <= 1'b0;
      pause_req        <= 1'b0;
      ram_addr         <= '0;
      ram_rd           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
    end else begin
      done   <= 1'b0;
      error  <= 1'b0;
      ram_rd <= 1'b0;

      // pend_cnt counts edges until the pending byte is captured; a newer strobe or the end of the upload supersedes it
      if (pend_cnt != 2'd0)
        pend_cnt <= pend_cnt - 2'd1;
      if (pend_cnt == 2'd1 && !strobe && !upload_end)
        ioctl_din <= pend_zero ? 8'h00 : ram_data;

      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              base_q    <= base_addr;
              len_q     <= length;
              timer     <= '0;
              pause_req <= 1'b1;
              busy      <= 1'b1;
              state     <= PAUSE_WAIT;
            end else begin
              done <= 1'b1;
            end
          end
        end

        PAUSE_WAIT: begin
          if (paused) begin
            timer            <= '0;
            ioctl_upload_req <= 1'b1;
            state            <= REQ;
          end else if (timer == TIMEOUT) begin
            pause_req <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        REQ: begin
          if (ioctl_upload && ioctl_index == UPLOAD_INDEX) begin
            ioctl_upload_req <= 1'b0;
            state            <= XFER;
          end else if (timer == TIMEOUT) begin
            ioctl_upload_req <= 1'b0;
            pause_req        <= 1'b0;
            busy             <= 1'b0;
            error            <= 1'b1;
            state            <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end

        XFER: begin
          if (!ioctl_upload) begin
            pause_req <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pend_cnt  <= '0;
            state     <= IDLE;
          end else if (ioctl_rd) begin
            if (in_window) begin
              ram_addr  <= base_q + ioctl_addr[ADDR_W-1:0];
              ram_rd    <= 1'b1;
              pend_zero <= 1'b0;
              pend_cnt  <= 2'(RAM_LAT + 1);
            end else begin
              pend_zero <= 1'b1;
              pend_cnt  <= 2'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_ram_uploader.sv
// Directed bench for ioctl_ram_uploader with a transaction-level reference model checked every cycle.
module tb_ioctl_ram_uploader;

  localparam int TMO = 100;
  localparam int M_IDLE = 0, M_WAIT = 1, M_REQ = 2, M_XFER = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] base_addr;
  logic [11:0] length;
  logic        paused;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_upload_req;
  logic        pause_req;
  logic [11:0] ram_addr;
  logic        ram_rd;
  logic [7:0]  ram_data = 8'h00;
  logic        busy;
  logic        done;
  logic        error;

  logic [7:0] mem [4096];

  int checks = 0;
  int errors = 0;

  ioctl_ram_uploader #(
    .ADDR_W(12), .LEN_W(12), .UPLOAD_INDEX(8'd4), .RAM_LAT(1), .TIMEOUT(24'd100)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .paused(paused), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din),
    .ioctl_upload_req(ioctl_upload_req), .pause_req(pause_req), .ram_addr(ram_addr),
    .ram_rd(ram_rd), .ram_data(ram_data), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one clock of read latency
  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: tracks the upload phase and schedules each byte's arrival on ioctl_din
  int         cyc = 0;
  int         mode = M_IDLE;
  int         entry = 0;
  int         m_base = 0;
  int         m_len = 0;
  bit         e_done = 1'b0, e_err = 1'b0, e_ram_rd = 1'b0;
  int         e_ram_addr = 0;
  logic [7:0] e_din = 8'h00;
  bit         due_v = 1'b0;
  int         due_c = 0;
  logic [7:0] due_val = 8'h00;

  initial forever begin
    @(posedge clk);
    cyc++;
    e_done = 1'b0;
    e_err = 1'b0;
    e_ram_rd = 1'b0;
    if (!reset_n) begin
      mode = M_IDLE;
      e_din = 8'h00;
      due_v = 1'b0;
    end else begin
      case (mode)
        M_IDLE:
          if (start) begin
            if (length != 12'd0) begin
              m_base = int'(base_addr);
              m_len = int'(length);
              mode = M_WAIT;
              entry = cyc;
            end else e_done = 1'b1;
          end
        M_WAIT:
          if (paused) begin
            mode = M_REQ;
            entry = cyc;
          end else if (cyc - entry > TMO) begin
            mode = M_IDLE;
            e_err = 1'b1;
          end
        M_REQ:
          if (ioctl_upload && ioctl_index == 8'd4) mode = M_XFER;
          else if (cyc - entry > TMO) begin
            mode = M_IDLE;
            e_err = 1'b1;
          end
        default:
          if (!ioctl_upload) begin
            mode = M_IDLE;
            e_done = 1'b1;
            due_v = 1'b0;
          end else if (ioctl_rd) begin
            due_v = 1'b1;
            if (int'(ioctl_addr) < m_len) begin
              e_ram_addr = (m_base + int'(ioctl_addr)) % 4096;
              e_ram_rd = 1'b1;
              due_c = cyc + 2;
              due_val = mem[e_ram_addr];
            end else begin
              due_c = cyc + 1;
              due_val = 8'h00;
            end
          end
      endcase
      if (due_v && due_c == cyc) begin
        e_din = due_val;
        due_v = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("busy", 32'(busy), 32'(mode != M_IDLE));
      chk("pause_req", 32'(pause_req), 32'(mode != M_IDLE));
      chk("upload_req", 32'(ioctl_upload_req), 32'(mode == M_REQ));
      chk("done", 32'(done), 32'(e_done));
      chk("error", 32'(error), 32'(e_err));
      chk("ram_rd", 32'(ram_rd), 32'(e_ram_rd));
      chk("ioctl_din", 32'(ioctl_din), 32'(e_din));
      if (e_ram_rd) chk("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  logic [7:0]  nom [4];
  logic [7:0]  wd [3];
  logic [11:0] wa [3];
  logic [7:0]  prev;
  int          n;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3;
    nom = '{8'h11, 8'h22, 8'h33, 8'h44};
    wa  = '{12'hFFE, 12'hFFF, 12'h000};
    wd  = '{8'hA1, 8'hB2, 8'hC3};

    reset_n = 1'b0; start = 1'b1; base_addr = 12'h100; length = 12'd4;
    paused = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0; ioctl_addr = '0;
    tick(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_din", 32'(ioctl_din), 32'h00);
    chk("rst_pause", 32'(pause_req), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h000);
    reset_n = 1'b1; start = 1'b0;
    tick(3);

    // Nominal four-byte upload
    start = 1'b1; base_addr = 12'h100; length = 12'd4;
    tick(1);
    start = 1'b0;
    tick(1);
    start = 1'b1; base_addr = 12'h200; length = 12'd0;   // ignored while busy
    tick(1);
    start = 1'b0;
    tick(2);
    paused = 1'b1;
    tick(1);
    chk("nom_upreq_rise", 32'(ioctl_upload_req), 32'd1);
    tick(3);
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick(1);
    chk("nom_upreq_drop", 32'(ioctl_upload_req), 32'd0);
    prev = 8'h00;
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 25'(i); ioctl_rd = 1'b1;
      tick(1);
      ioctl_rd = 1'b0;
      chk("nom_ram_rd", 32'(ram_rd), 32'd1);
      chk("nom_ram_addr", 32'(ram_addr), 32'(256 + i));
      tick(1);
      chk("nom_din_hold", 32'(ioctl_din), 32'(prev));
      tick(1);
      chk("nom_din", 32'(ioctl_din), 32'(nom[i]));
      prev = nom[i];
      tick(3);
    end
    ioctl_upload = 1'b0;
    tick(1);
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_pause_drop", 32'(pause_req), 32'd0);
    chk("nom_busy_drop", 32'(busy), 32'd0);
    paused = 1'b0; ioctl_index = 8'd0;
    tick(2);

    // Window wrapping past the top of RAM, plus an out-of-window read
    start = 1'b1; base_addr = 12'hFFE; length = 12'd3;
    tick(1);
    start = 1'b0; paused = 1'b1;
    tick(2);
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(i); ioctl_rd = 1'b1;
      tick(1);
      ioctl_rd = 1'b0;
      chk("wrap_ram_addr", 32'(ram_addr), 32'(wa[i]));
      tick(2);
      chk("wrap_din", 32'(ioctl_din), 32'(wd[i]));
      tick(2);
    end
    ioctl_addr = 25'd5; ioctl_rd = 1'b1;
    tick(1);
    ioctl_rd = 1'b0;
    chk("over_no_ram_rd", 32'(ram_rd), 32'd0);
    chk("over_din_hold", 32'(ioctl_din), 32'hC3);
    tick(1);
    chk("over_din_zero", 32'(ioctl_din), 32'h00);
    tick(2);

    // Back-to-back strobes: the later one wins
    ioctl_addr = 25'd1; ioctl_rd = 1'b1;
    tick(1);
    ioctl_addr = 25'd2;
    tick(1);
    ioctl_rd = 1'b0;
    tick(1);
    chk("b2b_no_first", 32'(ioctl_din), 32'h00);
    tick(1);
    chk("b2b_second", 32'(ioctl_din), 32'hC3);
    start = 1'b1; length = 12'd0;   // ignored while busy
    tick(1);
    start = 1'b0;
    chk("busy_start_no_done", 32'(done), 32'd0);
    tick(1);

    // Upload ends on the same cycle as a strobe
    ioctl_upload = 1'b0; ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    tick(1);
    ioctl_rd = 1'b0;
    chk("end_rd_done", 32'(done), 32'd1);
    chk("end_rd_no_ram_rd", 32'(ram_rd), 32'd0);
    tick(3);
    chk("end_rd_din_kept", 32'(ioctl_din), 32'hC3);
    paused = 1'b0; ioctl_index = 8'd0;
    tick(2);

    // Wrong index in REQ, then timeout
    paused = 1'b1;
    start = 1'b1; base_addr = 12'h000; length = 12'd1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk("wi_in_req", 32'(ioctl_upload_req), 32'd1);
    ioctl_upload = 1'b1; ioctl_index = 8'd3;
    n = 0;
    while (!error && n < 400) begin tick(1); n++; end
    chk("wi_timeout_cycles", 32'(n), 32'd101);
    chk("wi_pause_drop", 32'(pause_req), 32'd0);
    chk("wi_upreq_drop", 32'(ioctl_upload_req), 32'd0);
    chk("wi_busy_drop", 32'(busy), 32'd0);
    ioctl_upload = 1'b0; ioctl_index = 8'd0; paused = 1'b0;
    tick(2);

    // Pause never granted
    start = 1'b1; base_addr = 12'h000; length = 12'd8;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!error && n < 400) begin tick(1); n++; end
    chk("np_timeout_cycles", 32'(n), 32'd101);
    chk("np_busy_drop", 32'(busy), 32'd0);
    tick(2);

    // Zero-length request
    start = 1'b1; length = 12'd0;
    tick(1);
    start = 1'b0;
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_no_pause", 32'(pause_req), 32'd0);
    tick(1);
    chk("zl_done_pulse", 32'(done), 32'd0);
    tick(2);

    // Reset in the middle of a transfer
    paused = 1'b1;
    start = 1'b1; base_addr = 12'h100; length = 12'd4;
    tick(1);
    start = 1'b0;
    tick(1);
    ioctl_upload = 1'b1; ioctl_index = 8'd4;
    tick(1);
    ioctl_addr = 25'd0; ioctl_rd = 1'b1;
    tick(1);
    ioctl_rd = 1'b0; reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("mid_rst_pause", 32'(pause_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_din", 32'(ioctl_din), 32'h00);
    chk("mid_rst_done", 32'(done), 32'd0);
    ioctl_upload = 1'b0; paused = 1'b0; ioctl_index = 8'd0;
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
